// File: rtl/nbit_serializer.sv
// Parallel-to-serial converter: captures an N-bit word and sends it LSB first with a frame_done pulse.
// Optional even-parity trailer bit is enabled by defining NBIT_SERIALIZER_PARITY_EN.
module nbit_serializer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in0,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         out0,
    output logic         ser_valid,
    output logic         frame_done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef NBIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t         state;
    logic [N-1:0]   sreg;
    logic [CW-1:0]  cnt;

`ifdef NBIT_SERIALIZER_PARITY_EN
    logic par;

    function automatic logic even_parity(input logic [N-1:0] w);
        return ^w;
    endfunction
`endif

    // Outputs are registered and updated together with the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            out0       <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
`ifdef NBIT_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        sreg       <= in0;
                        cnt        <= '0;
                        out0       <= in0[0];
                        ser_valid  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef NBIT_SERIALIZER_PARITY_EN
                        par        <= even_parity(in0);
`endif
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
`ifdef NBIT_SERIALIZER_PARITY_EN
                        out0       <= par;
                        state      <= PARITY;
`else
                        out0       <= 1'b0;
                        ser_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
`endif
                    end else begin
                        // Next bit to present is the one that lands in bit 0 after this shift.
                        out0 <= sreg[1];
                    end
                end
`ifdef NBIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    out0       <= 1'b0;
                    ser_valid  <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= DONE;
                end
`endif
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    out0       <= 1'b0;
                    ser_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nbit_serializer.md
NBIT_SERIALIZER -- requirements
Module: nbit_serializer

Interface
REQ-001 The block SHALL have parameter N, default 32, setting the parallel word width (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port in0, input, N bits, the parallel word to be serialized.
REQ-005 The block SHALL have port load_valid, input, 1 bit, which requests capture of in0.
REQ-006 The block SHALL have port load_ready, output, 1 bit, asserted when the block can accept a word.
REQ-007 The block SHALL have port out0, output, 1 bit, the serial data bit.
REQ-008 The block SHALL have port ser_valid, output, 1 bit, asserted when out0 carries a frame bit.
REQ-009 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse marking the end of a frame.
REQ-010 The block SHALL have port busy, output, 1 bit, asserted in every state except IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, PARITY (present only when the configuration macro is defined) and DONE.
REQ-012 In IDLE: load_ready=1, ser_valid=0, out0=0, frame_done=0.
REQ-013 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; on that edge in0 is captured into the shift register, the bit counter is cleared and the state goes to SHIFT.
REQ-014 in0 SHALL be sampled only on the accept edge; later changes to in0 SHALL NOT affect the frame in progress.
REQ-015 In SHIFT: ser_valid=1 and out0 = shift register bit 0, which sends the word LSB first.
- Each edge shifts the register right by one and increments the counter.
REQ-016 After the edge that retires bit N-1, the state SHALL go to PARITY if the macro is defined, otherwise to DONE.
REQ-017 For an accept at edge k, bit i SHALL be valid in the cycle after edge k+i, for i = 0..N-1.
REQ-018 In DONE: frame_done=1 and ser_valid=0 for exactly one cycle, then the state goes to IDLE.
REQ-019 load_ready SHALL be 0 in SHIFT, PARITY and DONE; load_valid in those states SHALL be ignored, with no queuing.
REQ-020 Minimum spacing between accept edges SHALL be N+2 cycles without the macro and N+3 cycles with it.
REQ-021 The bit counter SHALL be wide enough to hold N with no wrap-around.
REQ-022 The counter SHALL NOT be referenced outside SHIFT.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, shift register=0, counter=0, out0=0, ser_valid=0, frame_done=0 and busy=0.
- After reset is released, load_ready=1.
REQ-024 A reset during SHIFT, PARITY or DONE SHALL abort the frame silently, with no frame_done pulse.
REQ-025 The first accept after release SHALL be possible on the first rising edge at which rst is low.

Configuration
REQ-026 The block SHALL support the macro NBIT_SERIALIZER_PARITY_EN.
REQ-027 With NBIT_SERIALIZER_PARITY_EN defined, the PARITY state SHALL follow SHIFT for one cycle.
- In PARITY: ser_valid=1 and out0 = XOR of all N captured bits (even parity); the next state is DONE.
REQ-028 Without NBIT_SERIALIZER_PARITY_EN, the PARITY state and its XOR logic SHALL NOT exist.
- Frames are exactly N bits.

Verification
REQ-029 Basic frame: N=32, no macro, load in0=32'hA5A5_0F0F in IDLE -> out0 sequence 1,1,1,1,0,0,0,0,... over 32 valid cycles, LSB first; frame_done pulses 1 cycle in cycle 33 after accept; load_ready returns in cycle 34.
REQ-030 Parity frame: N=8, macro defined, in0=8'b1011_0001 -> 8 data bits 1,0,0,0,1,1,0,1, then parity bit 0 with ser_valid=1, then frame_done.
REQ-031 Busy load: assert load_valid with in0=32'hFFFF_FFFF during SHIFT of 32'h0 -> ignored; out0 stays 0 for all 32 bits; no second frame starts.
REQ-032 Mid-frame reset: pulse rst during bit 10 of a 32-bit frame -> ser_valid=0, out0=0 and busy=0 immediately (before the next clock); no frame_done; a new load accepted on the first edge after release.
REQ-033 Back-to-back: load_valid held high with in0=1, then 2 -> accept edges 34 cycles apart (N=32, no macro); second frame out0=0,1,0,...
REQ-034 Input hold: change in0 every cycle after accept -> the serial stream equals the word captured at the accept edge.
